shift_seq_unit: RTL and testbench

// - Multi-cycle 16-bit shifter for the ALU. Moves the operand one bit position per clock in the

---
 rtl/shift_seq_unit_if.sv | 27 ++
 rtl/shift_seq_unit.sv | 171 +++++++++++++++++
 tb/tb_shift_seq_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_unit_if.sv
// rtl/shift_seq_unit_if.sv - request/response bundle for the multi-cycle shifter
interface shift_seq_unit_if #(
    parameter int WIDTH = 16,
    parameter int AMTW  = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMTW-1:0]  req_amt;
    logic             req_dir;
    logic [1:0]       req_mode;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_lost;
    logic             rsp_err;

    modport master (
        output req_valid, req_data, req_amt, req_dir, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_lost, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_lost, rsp_err
    );
endinterface

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - one-bit-per-clock 16-bit shifter; UNDO_EN adds inverse (mode 11) support
module shift_seq_unit #(
    parameter int WIDTH = 16,
    parameter int AMTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_seq_unit_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic             r_err;
    logic             r_dir;
    logic             r_rot;
    logic             r_arith;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_lost;
    logic [AMTW-1:0]  r_cnt;

`ifdef UNDO_EN
    logic             r_inv;
    logic [AMTW-1:0]  r_amt;
    logic             r_hist_valid;
    logic [WIDTH-1:0] r_hist_data;
    logic [WIDTH-1:0] r_hist_lost;
    logic [AMTW-1:0]  r_hist_amt;
    logic             r_hist_dir;
    logic             r_hist_rot;
`endif

    logic             w_out_bit;
    logic             w_fill;
    logic             w_record;
    logic [WIDTH-1:0] w_next;

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_data  = r_data;
    assign bus.rsp_lost  = r_lost;
    assign bus.rsp_err   = r_err;

    // Single-position step: pick the outgoing bit and the bit that refills the vacated end.
    always_comb begin
        w_out_bit = r_dir ? r_data[0] : r_data[WIDTH-1];
        w_record  = !r_rot;
        if (r_rot)
            w_fill = w_out_bit;
        else if (r_arith && r_dir)
            w_fill = r_data[WIDTH-1];
        else
            w_fill = 1'b0;
`ifdef UNDO_EN
        // The last forward step is undone first, so refill walks the lost vector upward from bit 0.
        if (r_inv) begin
            w_record = 1'b0;
            if (!r_rot)
                w_fill = r_hist_lost[r_amt - r_cnt];
        end
`endif
        w_next = r_dir ? {w_fill, r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], w_fill};
    end

    // Control FSM, working registers and (optionally) undo history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
            r_arith <= 1'b0;
            r_data  <= '0;
            r_lost  <= '0;
            r_cnt   <= '0;
`ifdef UNDO_EN
            r_inv        <= 1'b0;
            r_amt        <= '0;
            r_hist_valid <= 1'b0;
            r_hist_data  <= '0;
            r_hist_lost  <= '0;
            r_hist_amt   <= '0;
            r_hist_dir   <= 1'b0;
            r_hist_rot   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_state <= S_SHIFT;
                        r_data  <= bus.req_data;
                        r_lost  <= '0;
                        r_err   <= 1'b0;
                        r_dir   <= bus.req_dir;
                        r_rot   <= (bus.req_mode == 2'b10);
                        r_arith <= (bus.req_mode == 2'b01);
                        r_cnt   <= bus.req_amt;
`ifdef UNDO_EN
                        r_inv   <= 1'b0;
                        r_amt   <= bus.req_amt;
`endif
                        if (bus.req_mode == 2'b11) begin
`ifdef UNDO_EN
                            if (r_hist_valid) begin
                                r_data  <= r_hist_data;
                                r_cnt   <= r_hist_amt;
                                r_amt   <= r_hist_amt;
                                r_dir   <= ~r_hist_dir;
                                r_rot   <= r_hist_rot;
                                r_arith <= 1'b0;
                                r_inv   <= 1'b1;
                            end else begin
                                r_err   <= 1'b1;
                                r_cnt   <= '0;
                            end
`else
                            r_err <= 1'b1;
                            r_cnt <= '0;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_data <= w_next;
                        r_cnt  <= r_cnt - AMTW'(1);
                        if (w_record)
                            r_lost[r_cnt - AMTW'(1)] <= w_out_bit;
                    end
                    // A zero count still spends one cycle here so latency is never below one.
                    if (r_cnt <= AMTW'(1)) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
`ifdef UNDO_EN
                        if (!r_err) begin
                            if (r_inv) begin
                                r_hist_valid <= 1'b0;
                            end else begin
                                r_hist_valid <= 1'b1;
                                r_hist_data  <= r_data;
                                r_hist_lost  <= r_lost;
                                r_hist_amt   <= r_amt;
                                r_hist_dir   <= r_dir;
                                r_hist_rot   <= r_rot;
                            end
                        end
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - directed bench with a cycle-level reference model for shift_seq_unit
module tb_shift_seq_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    shift_seq_unit_if #(.WIDTH(16), .AMTW(4)) bus();

    shift_seq_unit #(.WIDTH(16), .AMTW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result of one forward operation, from the arithmetic definition of each mode.
    function automatic void calc(input logic [15:0] d, input logic [3:0] a, input logic dir,
                                 input logic [1:0] mode, output logic [15:0] rd,
                                 output logic [15:0] rl);
        logic signed [15:0] sd;
        int n;
        sd = d;
        n  = int'(a);
        rl = '0;
        if (mode == 2'b10) begin
            if (n == 0) rd = d;
            else if (dir) rd = (d >> n) | (d << (16 - n));
            else          rd = (d << n) | (d >> (16 - n));
        end else if (dir) begin
            rd = (mode == 2'b01) ? 16'(sd >>> n) : (d >> n);
            for (int j = 0; j < n; j++) rl[n-1-j] = d[j];
        end else begin
            rd = d << n;
            if (n != 0) rl = d >> (16 - n);
        end
    endfunction

    // Model state: busy/valid timing by countdown, expected response, and undo history.
    logic        m_armed = 1'b0;
    logic        m_busy, m_valid, m_err, m_inv, m_hv;
    int          m_cd;
    logic [15:0] m_data, m_lost, m_op, m_hop;
    logic [3:0]  m_amt, m_hamt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_hv    = 1'b0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1'b1;
                m_err  = 1'b0;
                m_inv  = 1'b0;
                m_op   = bus.req_data;
                m_amt  = bus.req_amt;
                if (bus.req_mode == 2'b11) begin
`ifdef UNDO_EN
                    if (m_hv) begin
                        m_inv  = 1'b1;
                        m_data = m_hop;
                        m_lost = '0;
                        m_cd   = (m_hamt == 0) ? 1 : int'(m_hamt);
                    end else begin
                        m_err = 1'b1;
                    end
`else
                    m_err = 1'b1;
`endif
                    if (m_err) begin
                        m_data = bus.req_data;
                        m_lost = '0;
                        m_cd   = 1;
                    end
                end else begin
                    calc(bus.req_data, bus.req_amt, bus.req_dir, bus.req_mode, m_data, m_lost);
                    m_cd = (bus.req_amt == 0) ? 1 : int'(bus.req_amt);
                end
            end
        end else if (!m_valid) begin
            m_cd--;
            if (m_cd == 0) m_valid = 1'b1;
        end else if (bus.rsp_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            if (!m_err) begin
                if (m_inv) m_hv = 1'b0;
                else begin
                    m_hv   = 1'b1;
                    m_hop  = m_op;
                    m_hamt = m_amt;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_armed) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
                chk("rsp_lost", 32'(bus.rsp_lost), 32'(m_lost));
                chk("rsp_err",  32'(bus.rsp_err),  32'(m_err));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Issue one request, time the response, check literals, optionally stall, then accept it.
    task automatic do_op(input string nm, input logic [15:0] d, input logic [3:0] a,
                         input logic dir, input logic [1:0] mode, input int lat,
                         input logic [15:0] ed, input logic [15:0] el, input logic ee,
                         input int hold);
        int  k;
        bit  seen;
        bus.req_data  = d;
        bus.req_amt   = a;
        bus.req_dir   = dir;
        bus.req_mode  = mode;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            step();
            k++;
            seen = bus.rsp_valid;
        end
        chk({nm, "_latency"}, 32'(k), 32'(lat));
        if (seen) begin
            chk({nm, "_data"}, 32'(bus.rsp_data), 32'(ed));
            chk({nm, "_lost"}, 32'(bus.rsp_lost), 32'(el));
            chk({nm, "_err"},  32'(bus.rsp_err),  32'(ee));
            for (int h = 0; h < hold; h++) begin
                bus.req_valid = 1'b1;
                bus.req_data  = 16'hDEAD;
                bus.req_amt   = 4'd2;
                bus.req_mode  = 2'b00;
                step();
                chk({nm, "_hold_data"},  32'(bus.rsp_data),  32'(ed));
                chk({nm, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            chk({nm, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b1;
        bus.req_data  = 16'hBEEF;
        bus.req_amt   = 4'd3;
        bus.req_dir   = 1'b0;
        bus.req_mode  = 2'b00;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_data",  32'(bus.rsp_data),  32'd0);
        chk("reset_lost",  32'(bus.rsp_lost),  32'd0);
        chk("reset_err",   32'(bus.rsp_err),   32'd0);
        step();

        do_op("lsl3",    16'h8001, 4'd3,  1'b0, 2'b00, 3,  16'h0008, 16'h0004, 1'b0, 0);
        do_op("asr4",    16'hF000, 4'd4,  1'b1, 2'b01, 4,  16'hFF00, 16'h0000, 1'b0, 0);
        do_op("ror1",    16'h0001, 4'd1,  1'b1, 2'b10, 1,  16'h8000, 16'h0000, 1'b0, 0);
        do_op("lsr1_bp", 16'h8001, 4'd1,  1'b1, 2'b00, 1,  16'h4000, 16'h0001, 1'b0, 5);
        do_op("amt0",    16'h1234, 4'd0,  1'b0, 2'b00, 1,  16'h1234, 16'h0000, 1'b0, 0);
        do_op("asl1",    16'h8001, 4'd1,  1'b0, 2'b01, 1,  16'h0002, 16'h0001, 1'b0, 0);
        do_op("rol4",    16'h8001, 4'd4,  1'b0, 2'b10, 4,  16'h0018, 16'h0000, 1'b0, 0);
        do_op("lsl15",   16'hFFFF, 4'd15, 1'b0, 2'b00, 15, 16'h8000, 16'h7FFF, 1'b0, 0);
        do_op("asr15",   16'h8000, 4'd15, 1'b1, 2'b01, 15, 16'hFFFF, 16'h0000, 1'b0, 0);

        bus.req_data  = 16'h1234;
        bus.req_amt   = 4'd10;
        bus.req_dir   = 1'b0;
        bus.req_mode  = 2'b00;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (12) step();
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);

        do_op("inv_empty", 16'h5555, 4'd0, 1'b0, 2'b11, 1, 16'h5555, 16'h0000, 1'b1, 0);
        do_op("fwd_a5c3",  16'hA5C3, 4'd5, 1'b1, 2'b00, 5, 16'h052E, 16'h0018, 1'b0, 0);
`ifdef UNDO_EN
        do_op("inv1", 16'h1234, 4'd0, 1'b0, 2'b11, 5, 16'hA5C3, 16'h0000, 1'b0, 0);
`else
        do_op("inv1", 16'h1234, 4'd0, 1'b0, 2'b11, 1, 16'h1234, 16'h0000, 1'b1, 0);
`endif
        do_op("inv2", 16'h4321, 4'd0, 1'b0, 2'b11, 1, 16'h4321, 16'h0000, 1'b1, 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
